// File: rtl/pkt_replay_pkg.sv
// Shared types and packet field map for the packet replay engine.
// Field offsets describe the response packet decode.
package pkt_replay_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t SEND  = 3'd1;
  localparam state_t GAP   = 3'd2;
  localparam state_t DRAIN = 3'd3;
  localparam state_t DONE  = 3'd4;

  localparam int TS_BIT           = 0;
  localparam int SPIKE_BIT        = 4;
  localparam int NODE_LSB         = 5;
  localparam int NODE_W           = 2;
  localparam int RES_LSB          = 16;
  localparam int RES_W            = 17;
  localparam int MIN_PACKET_WIDTH = 33;

endpackage

// File: rtl/pkt_replay_engine_table.sv
// Packet table: DEPTH x PW register array,
// one write port, combinational read port.
module pkt_table #(
  parameter int PW    = 33,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [PW-1:0] rdata
);

  logic [PW-1:0] mem_q [DEPTH];

  // Table storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pkt_replay_engine.sv
// Packet replay engine: replays a packet table over valid/ready
// and sinks/decodes responses. Option: PKT_REPLAY_CHECKSUM_EN.
module pkt_replay_engine
  import pkt_replay_pkg::*;
#(
  parameter int PACKET_WIDTH = 33,
  parameter int DEPTH        = 32,
  parameter int GAP_W        = 8,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 1024,
  parameter int PW           = PACKET_WIDTH,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [PW-1:0]      cfg_wdata,
  input  logic               start,
  input  logic               abort,
  input  logic [AW:0]        num_pkts,
  input  logic [GAP_W-1:0]   gap,
  input  logic               loop_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PW-1:0]      out_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PW-1:0]      in_data,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   sent_cnt,
  output logic [CNT_W-1:0]   rcvd_cnt,
  output logic               rx_timestep,
  output logic               rx_spike,
  output logic [NODE_W-1:0]  rx_node,
`ifdef PKT_REPLAY_CHECKSUM_EN
  output logic [RES_W-1:0]   rx_residue,
  output logic [PW-1:0]      tx_csum,
  output logic [PW-1:0]      rx_csum
`else
  output logic [RES_W-1:0]   rx_residue
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW:0]        num_q, num_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic               loop_q, loop_d;
  logic [TW-1:0]      to_q, to_d;
  logic               tmo_q, tmo_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [CNT_W-1:0]   rcvd_q, rcvd_d;
  logic               rdy_q, rdy_d;
  logic               ts_q, ts_d;
  logic               spk_q, spk_d;
  logic [NODE_W-1:0]  node_q, node_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [PW-1:0]      rdata;
  logic               out_fire;
  logic               in_fire;
  logic               last;
  logic               tbl_we;
  logic               unused_in;

  assign tbl_we   = cfg_we && (state_q == IDLE);
  assign out_fire = out_valid && out_ready;
  assign in_fire  = in_valid && rdy_q;
  assign last     = ({1'b0, idx_q} == (num_q - 1'b1));

  pkt_table #(
    .PW    (PW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (idx_q),
    .rdata (rdata)
  );

  // Replay FSM, sink decode and saturating counters.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    loop_d  = loop_q;
    to_d    = to_q;
    tmo_d   = tmo_q;
    sent_d  = sent_q;
    rcvd_d  = rcvd_q;
    rdy_d   = 1'b1;
    ts_d    = ts_q;
    spk_d   = spk_q;
    node_d  = node_q;
    res_d   = res_q;

    if (in_fire) begin
      rcvd_d = (&rcvd_q) ? rcvd_q : rcvd_q + 1'b1;
      ts_d   = in_data[TS_BIT];
      spk_d  = in_data[SPIKE_BIT];
      node_d = in_data[NODE_LSB +: NODE_W];
      res_d  = in_data[RES_LSB +: RES_W];
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_pkts;
          gap_d   = gap;
          loop_d  = loop_en;
          idx_d   = '0;
          sent_d  = '0;
          rcvd_d  = '0;
          tmo_d   = 1'b0;
          state_d = (num_pkts != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (out_fire) begin
          sent_d = (&sent_q) ? sent_q : sent_q + 1'b1;
          if (last && !loop_q) begin
            state_d = DRAIN;
            to_d    = '0;
          end else begin
            idx_d = last ? '0 : idx_q + 1'b1;
            if (gap_q != '0) begin
              state_d = GAP;
              gcnt_d  = gap_q;
            end
          end
          if (abort) state_d = DONE;
        end else if (abort) begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = DONE;
        end else if (gcnt_q <= 1) begin
          state_d = SEND;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      DRAIN: begin
        if (rcvd_q >= sent_q) begin
          state_d = DONE;
        end else if (in_fire) begin
          to_d = '0;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      loop_q  <= 1'b0;
      to_q    <= '0;
      tmo_q   <= 1'b0;
      sent_q  <= '0;
      rcvd_q  <= '0;
      rdy_q   <= 1'b0;
      ts_q    <= 1'b0;
      spk_q   <= 1'b0;
      node_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      loop_q  <= loop_d;
      to_q    <= to_d;
      tmo_q   <= tmo_d;
      sent_q  <= sent_d;
      rcvd_q  <= rcvd_d;
      rdy_q   <= rdy_d;
      ts_q    <= ts_d;
      spk_q   <= spk_d;
      node_q  <= node_d;
      res_q   <= res_d;
    end
  end

`ifdef PKT_REPLAY_CHECKSUM_EN
  logic [PW-1:0] txc_q, txc_d;
  logic [PW-1:0] rxc_q, rxc_d;

  // Running XOR of sent and received packets.
  always_comb begin
    txc_d = txc_q;
    rxc_d = rxc_q;
    if (out_fire) txc_d = txc_q ^ out_data;
    if (in_fire)  rxc_d = rxc_q ^ in_data;
    if (state_q == IDLE && start) begin
      txc_d = '0;
      rxc_d = '0;
    end
  end

  // Checksum registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txc_q <= '0;
      rxc_q <= '0;
    end else begin
      txc_q <= txc_d;
      rxc_q <= rxc_d;
    end
  end

  assign tx_csum = txc_q;
  assign rx_csum = rxc_q;
`endif

  assign unused_in   = ^in_data;
  assign out_valid   = (state_q == SEND);
  assign out_data    = out_valid ? rdata : '0;
  assign in_ready    = rdy_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign timeout     = tmo_q;
  assign sent_cnt    = sent_q;
  assign rcvd_cnt    = rcvd_q;
  assign rx_timestep = ts_q;
  assign rx_spike    = spk_q;
  assign rx_node     = node_q;
  assign rx_residue  = res_q;

endmodule

// File: tb/tb_pkt_replay_engine.sv
// Self-checking bench for pkt_replay_engine: response decode table,
// replay scoreboard and multi-cycle corner sequences.
module tb_pkt_replay_engine;

  localparam int PW      = 33;
  localparam int AW      = 5;
  localparam int GAP_W   = 8;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [PW-1:0]     cfg_wdata = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [AW:0]       num_pkts = '0;
  logic [GAP_W-1:0]  gap = '0;
  logic              loop_en = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PW-1:0]     out_data;
  logic              in_valid;
  logic              in_ready;
  logic [PW-1:0]     in_data;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  sent_cnt;
  logic [CNT_W-1:0]  rcvd_cnt;
  logic              rx_timestep;
  logic              rx_spike;
  logic [1:0]        rx_node;
  logic [16:0]       rx_residue;
`ifdef PKT_REPLAY_CHECKSUM_EN
  logic [PW-1:0]     tx_csum;
  logic [PW-1:0]     rx_csum;
`endif

  logic              lb = 1'b0;
  logic              tb_in_valid = 1'b0;
  logic [PW-1:0]     tb_in_data = '0;

  assign in_valid = lb ? (out_valid && out_ready) : tb_in_valid;
  assign in_data  = lb ? out_data : tb_in_data;

  always #5 clk = ~clk;

  pkt_replay_engine dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .start       (start),
    .abort       (abort),
    .num_pkts    (num_pkts),
    .gap         (gap),
    .loop_en     (loop_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .sent_cnt    (sent_cnt),
    .rcvd_cnt    (rcvd_cnt),
    .rx_timestep (rx_timestep),
    .rx_spike    (rx_spike),
    .rx_node     (rx_node),
`ifdef PKT_REPLAY_CHECKSUM_EN
    .rx_residue  (rx_residue),
    .tx_csum     (tx_csum),
    .rx_csum     (rx_csum)
`else
    .rx_residue  (rx_residue)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  logic [PW-1:0] exp_q[$];
  int            cyc_q[$];
  int            cyc_n  = 0;
  int            xfer_n = 0;

  // Scoreboard: a transfer seen at negedge completes on the next posedge.
  always @(negedge clk) begin
    cyc_n++;
    if (!rst && out_valid && out_ready) begin
      xfer_n++;
      cyc_q.push_back(cyc_n);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_extra: got %0h want none", out_data);
      end else begin
        chk("sb_pkt", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [PW-1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_wdata = d;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic launch(input int n, input int g, input logic l);
    num_pkts = (AW+1)'(n);
    gap      = GAP_W'(g);
    loop_en  = l;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k);
    k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL done_wait: got no done want done within %0d", budget);
    end
  endtask

  typedef struct {
    logic [PW-1:0] din;
    logic          ts;
    logic          sp;
    logic [1:0]    node;
    logic [16:0]   res;
  } vec_t;

  vec_t vt[5];

  initial begin
    int k;
    int base;

    vt[0] = '{33'h1_2345_0075, 1'b1, 1'b1, 2'd3, 17'h12345};
    vt[1] = '{33'h0_0000_0000, 1'b0, 1'b0, 2'd0, 17'h00000};
    vt[2] = '{33'h1_FFFF_FFFF, 1'b1, 1'b1, 2'd3, 17'h1FFFF};
    vt[3] = '{33'h0_8001_0041, 1'b1, 1'b0, 2'd2, 17'h08001};
    vt[4] = '{33'h0_0000_0010, 1'b0, 1'b1, 2'd0, 17'h00000};

    // Reset state
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_rcvd", rcvd_cnt, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    step();
    chk("in_ready_after_rst", in_ready, 1);

    // 1: back-to-back replay of 4 entries, loopback
    for (int i = 0; i < 4; i++) wr(i, PW'(i + 1));
    lb = 1'b1;
    out_ready = 1'b1;
    cyc_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(PW'(i + 1));
    launch(4, 0, 1'b0);
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_data", out_data, 1);
    wait_done(100, k);
    chk("t1_sent", sent_cnt, 4);
    chk("t1_rcvd", rcvd_cnt, 4);
    chk("t1_timeout", timeout, 0);
    chk("t1_xfers", cyc_q.size(), 4);
    if (cyc_q.size() == 4) chk("t1_span", cyc_q[3] - cyc_q[0], 3);
    step();
    chk("t1_idle", busy, 0);

    // 2: gap of 3 idle cycles between two packets
    cyc_q.delete();
    exp_q.push_back(PW'(1));
    exp_q.push_back(PW'(2));
    launch(2, 3, 1'b0);
    wait_done(100, k);
    chk("t2_xfers", cyc_q.size(), 2);
    if (cyc_q.size() == 2) chk("t2_spacing", cyc_q[1] - cyc_q[0], 4);
    step();

    // 3: backpressure mid-stream
    cyc_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(PW'(i + 1));
    launch(4, 0, 1'b0);
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data", out_data, 3);
      step();
    end
    out_ready = 1'b1;
    wait_done(100, k);
    chk("t3_sent", sent_cnt, 4);
    chk("t3_xfers", cyc_q.size(), 4);
    chk("t3_sb_empty", exp_q.size(), 0);
    step();

    // 4: looping replay aborted on the 10th transfer
    for (int i = 0; i < 10; i++) exp_q.push_back(PW'((i % 4) + 1));
    base = xfer_n;
    launch(4, 0, 1'b1);
    k = 0;
    while (xfer_n - base < 9 && k < 100) begin
      step();
      k++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_sent", sent_cnt, 10);
    chk("t4_rcvd", rcvd_cnt, 10);
    chk("t4_timeout", timeout, 0);
    chk("t4_sb_empty", exp_q.size(), 0);
    step();
    chk("t4_idle", busy, 0);

    // num_pkts == 0 goes straight to DONE
    launch(0, 0, 1'b0);
    chk("n0_done", done, 1);
    chk("n0_sent", sent_cnt, 0);
    step();
    chk("n0_idle", busy, 0);
    chk("n0_done_pulse", done, 0);

    // cfg write coincident with start is seen by the replay
    exp_q.push_back(PW'('h55));
    cfg_we    = 1'b1;
    cfg_addr  = '0;
    cfg_wdata = PW'('h55);
    launch(1, 0, 1'b0);
    cfg_we    = 1'b0;
    chk("wr_start_data", out_data, 'h55);
    wait_done(100, k);
    step();

    // 5: no responses -> DRAIN timeout
    lb = 1'b0;
    exp_q.push_back(PW'('h55));
    exp_q.push_back(PW'(2));
    launch(2, 0, 1'b0);
    k = 0;
    while (sent_cnt != 2 && k < 20) begin
      step();
      k++;
    end
    wait_done(2000, k);
    chk("t5_latency", k, TIMEOUT);
    chk("t5_timeout", timeout, 1);
    chk("t5_sent", sent_cnt, 2);
    chk("t5_rcvd", rcvd_cnt, 0);
    step();
    chk("t5_sticky", timeout, 1);
    chk("t5_idle", busy, 0);

    // 6: response decode table, in IDLE
    for (int i = 0; i < 5; i++) begin
      tb_in_valid = 1'b1;
      tb_in_data  = vt[i].din;
      step();
      tb_in_valid = 1'b0;
      chk("rx_timestep", rx_timestep, vt[i].ts);
      chk("rx_spike", rx_spike, vt[i].sp);
      chk("rx_node", rx_node, vt[i].node);
      chk("rx_residue", rx_residue, vt[i].res);
      chk("rx_cnt", rcvd_cnt, i + 1);
    end

    // reset in the middle of SEND
    out_ready = 1'b0;
    launch(2, 0, 1'b0);
    chk("mid_busy", busy, 1);
    chk("mid_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_rcvd", rcvd_cnt, 0);
    chk("mrst_residue", rx_residue, 0);
    chk("mrst_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    step();
    chk("mrst_in_ready_back", in_ready, 1);
    chk("mrst_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
